// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the sequential multiply units in the arithmetic datapath.
//   mul_state_e  : controller state encoding (IDLE, RUN)
//   arith_word_t : wide scratch word used by the width-generic helpers below
//   prodWidth    : full product width for a given operand width
//   widthMask    : low-order mask of a given width
//   negateMod    : two's-complement negate, reduced mod 2^width
//   absMag       : magnitude of a width-bit value, signed or unsigned
// The helpers work on a 128-bit scratch word so that one function body can
// serve any operand width. Callers zero-extend into arith_word_t and slice
// the low bits back out. This limits products to 127 bits, so WIDTH <= 63.
package mul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mul_state_e;

    localparam int MAX_ARITH_W = 128;

    typedef logic [MAX_ARITH_W-1:0] arith_word_t;

    function automatic int prodWidth(input int width);
        return 2 * width;
    endfunction

    function automatic arith_word_t widthMask(input int width);
        if (width >= MAX_ARITH_W) begin
            return '1;
        end
        return (arith_word_t'(1) << width) - arith_word_t'(1);
    endfunction

    function automatic arith_word_t negateMod(input arith_word_t x, input int width);
        return (~x + arith_word_t'(1)) & widthMask(width);
    endfunction

    // The most negative value negates to itself. Read as unsigned, that is
    // exactly its magnitude, so it needs no special case.
    function automatic arith_word_t absMag(input arith_word_t x, input int width,
                                           input logic isSigned);
        arith_word_t msbShifted;
        msbShifted = x >> (width - 1);
        if (isSigned && msbShifted[0]) begin
            return negateMod(x, width);
        end
        return x & widthMask(width);
    endfunction

endpackage

// File: rtl/shift_add_dp.sv
// shift_add_dp
// Datapath of the shift-and-add multiplier. It holds the accumulator, the
// shifting multiplicand and multiplier registers, and the sign of the result.
// The controller steers it with two qualifiers.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset, clears every register
//   load_i      : capture operand magnitudes and result sign, clear acc
//   step_i      : process one multiplier bit (add-if-set, shift both)
//   sgn_i       : operands are two's complement (used with load_i)
//   a_i, b_i    : multiplicand / multiplier (used with load_i)
//   mplrZero_o  : no multiplier bits left, so the accumulator is final
//   result_o    : accumulator with the sign fix-up applied
import mul_pkg::*;

module shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 sgn_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 mplrZero_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int PW = prodWidth(WIDTH);

    logic [PW-1:0]    acc_q,   acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q,  mplr_d;
    logic             neg_q,   neg_d;

    arith_word_t aAbsWide;
    arith_word_t bAbsWide;
    arith_word_t accNegWide;
    logic        unusedHighBits;

    // Magnitudes are formed in the wide scratch word. absMag masks to WIDTH
    // bits, so the low PW bits of aAbsWide already hold |a| zero-extended.
    assign aAbsWide   = absMag(arith_word_t'(a_i), WIDTH, sgn_i);
    assign bAbsWide   = absMag(arith_word_t'(b_i), WIDTH, sgn_i);
    assign accNegWide = negateMod(arith_word_t'(acc_q), PW);

    assign unusedHighBits = ^{aAbsWide[MAX_ARITH_W-1:PW],
                              bAbsWide[MAX_ARITH_W-1:WIDTH],
                              accNegWide[MAX_ARITH_W-1:PW]};

    // Loading takes priority. The controller never raises both qualifiers in
    // the same cycle, but the order keeps the behaviour obvious if it did.
    always_comb begin
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        neg_d   = neg_q;
        if (load_i) begin
            acc_d   = '0;
            mcand_d = aAbsWide[PW-1:0];
            mplr_d  = bAbsWide[WIDTH-1:0];
            neg_d   = sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (step_i) begin
            if (mplr_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            neg_q   <= neg_d;
        end
    end

    assign mplrZero_o = (mplr_q == '0);
    assign result_o   = neg_q ? accNegWide[PW-1:0] : acc_q;

endmodule

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul
// Multi-cycle shift-and-add multiplier with a start/busy/done handshake.
// Latency is the bit length of |b| plus one cycle. The loop exits as soon
// as no multiplier bits remain.
//   clk_i     : clock, all state changes on the rising edge
//   rst_i     : synchronous active-high reset, aborts any operation
//   start_i   : request, only honoured in IDLE
//   sgn_i     : 1 = two's-complement operands, sampled with start
//   a_i, b_i  : multiplicand / multiplier, sampled with start
//   busy_o    : operation in flight
//   done_o    : one-cycle completion pulse, product valid from this cycle
//   product_o : 2*WIDTH-bit result, held until the next completion
import mul_pkg::*;

module seq_shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sgn_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int PW = prodWidth(WIDTH);

    mul_state_e    state_q;
    logic          busy_q;
    logic          done_q;
    logic [PW-1:0] product_q;

    logic          loadOp;
    logic          stepOp;
    logic          mplrZero;
    logic [PW-1:0] result;

    // A start that arrives during RUN simply never reaches the datapath.
    assign loadOp = (state_q == IDLE) && start_i;
    assign stepOp = (state_q == RUN) && !mplrZero;

    shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (loadOp),
        .step_i     (stepOp),
        .sgn_i      (sgn_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .mplrZero_o (mplrZero),
        .result_o   (result)
    );

    // The controller and handshake outputs are registered together, so busy
    // and done always change on the same edge and are never both high.
    // product_q is written only on the completion edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (mplrZero) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= result;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// tb_seq_shift_add_mul
// Directed and randomized checks of seq_shift_add_mul at WIDTH=16. Expected
// products and latencies come from integer arithmetic on the operands.
module tb_seq_shift_add_mul;

    localparam int WIDTH = 16;
    localparam int PW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic            busy;
    logic            done;
    logic [PW-1:0]   product;

    int checks = 0;
    int errors = 0;
    logic [PW-1:0] lastProduct;

    seq_shift_add_mul #(
        .WIDTH(WIDTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .sgn_i     (sgn),
        .a_i       (a),
        .b_i       (b),
        .busy_o    (busy),
        .done_o    (done),
        .product_o (product)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] modelProduct(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(y));
        else   p = longint'(x) * longint'(y);
        return p[PW-1:0];
    endfunction

    function automatic int modelLatency(input logic [WIDTH-1:0] y, input logic s);
        int m;
        int n;
        m = s ? int'($signed(y)) : int'(y);
        if (m < 0) m = -m;
        n = 0;
        while (m > 0) begin
            n++;
            m = m / 2;
        end
        return n + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts an operation at #1 after an edge and returns at #1 after the
    // edge where done is seen (or the budget runs out). intrudeAt > 0 pulses
    // a stray start during that cycle of the run.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opS, input int intrudeAt, input string tag);
        logic [PW-1:0] expP;
        int expLat;
        int lat;
        expP   = modelProduct(opA, opB, opS);
        expLat = modelLatency(opB, opS);
        lat    = 0;
        start = 1'b1; a = opA; b = opB; sgn = opS;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
        checkOutput({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int k = 1; k <= WIDTH + 4 && lat == 0; k++) begin
            if (k == intrudeAt) begin
                start = 1'b1;
                a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) lat = k;
            else checkOutput({tag, " product_hold"}, 64'(product), 64'(lastProduct));
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, " busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, " product"}, 64'(product), 64'(expP));
        lastProduct = expP;
    endtask

    task automatic idleCheck(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, " done_one_cycle"}, 64'(done), 64'd0);
        checkOutput({tag, " idle_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " idle_product"}, 64'(product), 64'(lastProduct));
    endtask

    initial begin
        int doneCount;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic rs;

        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        lastProduct = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset product", 64'(product), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(16'd3, 16'd5, 1'b0, 0, "u3x5");
        checkOutput("u3x5 value", 64'(product), 64'h0000000F);
        idleCheck("u3x5");
        applyStimulus(16'd1234, 16'd0, 1'b0, 0, "b_zero");
        idleCheck("b_zero");
        applyStimulus(16'd0, 16'hFFFF, 1'b0, 0, "a_zero");
        applyStimulus(16'hFFFD, 16'd7, 1'b1, 0, "s_m3x7");
        checkOutput("s_m3x7 value", 64'(product), 64'hFFFFFFEB);
        applyStimulus(16'hFFFD, 16'd7, 1'b0, 0, "u_fffdx7");
        checkOutput("u_fffdx7 value", 64'(product), 64'h0006FFEB);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 0, "u_max");
        checkOutput("u_max value", 64'(product), 64'hFFFE0001);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 0, "s_min_sq");
        checkOutput("s_min_sq value", 64'(product), 64'h40000000);
        applyStimulus(16'h8000, 16'd1, 1'b1, 0, "s_min_x1");
        checkOutput("s_min_x1 value", 64'(product), 64'hFFFF8000);
        idleCheck("s_min_x1");

        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 3, "intrude");
        idleCheck("intrude");

        applyStimulus(16'd1234, 16'd5678, 1'b1, 0, "b2b_first");
        applyStimulus(16'hFFFF, 16'h0003, 1'b0, 0, "b2b_second");
        idleCheck("b2b");

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            rs = 1'($urandom);
            applyStimulus(ra, rb, rs, 0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) idleCheck($sformatf("rand%0d", i));
        end

        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lastProduct = '0;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset product", 64'(product), 64'd0);
        doneCount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        checkOutput("midreset no_done", 64'(doneCount), 64'd0);

        applyStimulus(16'd300, 16'hFF9C, 1'b1, 0, "after_reset");
        idleCheck("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mul.md
# seq_shift_add_mul

Parametrised sequential multiplier, the next generation of the team's repeated-addition multiplier. It replaces the decrement-and-add loop with shift-and-add, so latency scales with the operand's bit length rather than its value. It adds signed mode, a full 2×WIDTH product and a start/busy/done handshake. The block sits in the arithmetic datapath as a multi-cycle multiply unit driven by a host controller.

## Interface
- WIDTH, 16, operand width in bits (≥2); product is 2×WIDTH.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in flight (RUN).
- done  out  1  one-cycle pulse; product valid from this cycle.
- product  out  2×WIDTH  result; held until the next operation completes.

## Operation
- States: IDLE, RUN. The state encoding is a shared enum.
- **IDLE:** on start=1, latch the following, then go to RUN:
  - mcand = |a| zero-extended to 2×WIDTH.
  - mplr = |b| as WIDTH-bit unsigned.
  - neg = sgn & (a[MSB] ^ b[MSB]).
  - acc = 0.
- **Magnitudes:** in signed mode, |x| = two's-complement negate if x[MSB] is set. The most negative value 2^(WIDTH-1) is representable as unsigned WIDTH bits. In unsigned mode, |x| = x.
- **RUN, mplr ≠ 0:** do the following, then stay in RUN:
  - if mplr[0], acc += mcand;
  - mcand <<= 1;
  - mplr >>= 1.
- **RUN, mplr == 0 (early termination):**
  - product <= neg ? −acc : acc;
  - done <= 1 for one cycle;
  - go to IDLE.
- Arithmetic is mod 2^(2×WIDTH). The true product always fits in 2×WIDTH bits, so no overflow or saturation is needed.
- start while busy=1 is ignored: no queueing, no error.
- a, b and sgn are don't-care except in the start cycle in IDLE.
- product changes only on the completion edge or on reset.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0. Internal acc, mcand, mplr and neg are cleared to 0.
- Reset mid-operation aborts the operation. The next cycle shows busy=0, done=0, product=0, and no done pulse follows.
- Start accepted at edge E0 → busy=1 from E0.
- n = bit length of |b| (0 for b=0). Edges E1..En process bits. Edge E(n+1) completes: busy=0 and done=1 in the following cycle.
- Latency from the start edge to done is n+1 cycles. Minimum is 1 (b=0); maximum is WIDTH+1.
- Back-to-back operation: start may be asserted in the same cycle done=1 (state is IDLE). It is accepted, and product holds the previous result until the new completion.
- done is never high while busy is high.

## Structure
- Package mul_pkg holds:
  - the state enum (IDLE, RUN);
  - a localparam or function computing product width 2×WIDTH;
  - an abs/negate helper function shared with other arithmetic blocks.
- Split the block into controller and datapath, matching the existing multiplier split:
  - sub-module shift_add_dp holds the acc, mcand and mplr registers, the adder/shifter, the mplr==0 flag and the sign fix-up;
  - the top seq_shift_add_mul holds the FSM and the handshake outputs.

## Test plan
All scenarios use WIDTH=16.
- Unsigned small: a=3, b=5, sgn=0 → done 4 cycles after start; product=32'h0000000F.
- Zero multiplier: a=1234, b=0 → done 1 cycle after start; product=0. Also check a=0, b=16'hFFFF → product=0 after 17 cycles.
- Signed mixed: a=16'hFFFD (−3), b=7, sgn=1 → product=32'hFFFFFFEB (−21), latency 4. Same operands with sgn=0 → product=32'h0006FFEB.
- Extremes:
  - 65535×65535 unsigned → 32'hFFFE0001, latency 17;
  - signed 16'h8000×16'h8000 → 32'h40000000, latency 17;
  - signed 16'h8000×1 → 32'hFFFF8000.
- Handshake:
  - start pulsed during busy is ignored and the first result is unchanged;
  - start in the done cycle launches a second op, and product holds the old value until the new done.
- Reset mid-op: rst at cycle 3 of a 17-cycle op → busy=0, done=0, product=0 next cycle; no spurious done afterwards.
